// File: rtl/programmable_irq_ctrl_if.sv
// CPU-side register/acknowledge bus plus peripheral request lines of the interrupt controller.
interface programmable_irq_ctrl_if #(
  parameter int NUM_IRQ = 8,
  parameter int DATA_W  = 32,
  parameter int VEC_W   = 8
);
  logic [NUM_IRQ-1:0] ir;
  logic               wr_en;
  logic [1:0]         wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic [1:0]         rd_addr;
  logic [DATA_W-1:0]  rd_data;
  logic               inta_req;
  logic               intr;
  logic               vec_valid;
  logic [VEC_W-1:0]   vector;
  logic               spurious;

  modport master (
    output ir, wr_en, wr_addr, wr_data, rd_addr, inta_req,
    input  rd_data, intr, vec_valid, vector, spurious
  );

  modport slave (
    input  ir, wr_en, wr_addr, wr_data, rd_addr, inta_req,
    output rd_data, intr, vec_valid, vector, spurious
  );
endinterface

// File: rtl/programmable_irq_ctrl.sv
// Interrupt controller: edge/level request latching, masking, nested fixed or rotating
// priority, vectored acknowledge with in-service tracking and explicit or automatic EOI.
module programmable_irq_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int DATA_W  = 32,
  parameter int VEC_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  programmable_irq_ctrl_if.slave bus
);
  localparam int ID_W = $clog2(NUM_IRQ);
  typedef logic [NUM_IRQ-1:0] irq_vec_t;
  typedef logic [ID_W-1:0]    id_t;

  irq_vec_t         irr, isr, mask, ir_q;
  irq_vec_t         irr_nxt, isr_nxt, pend;
  logic [2:0]       ctrl;
  logic [VEC_W-1:0] base;
  id_t              ptr, ptr_nxt, ptr_eff;
  logic             intr, vec_valid, spurious;
  logic [VEC_W-1:0] vector;
  logic             p_found, s_found, eligible;
  id_t              p_id, s_id, eoi_id;
  logic             ack_go, ack_hit, eoi_wr, eoi_eff;
  logic             unused_wr_data;

  // Highest-ranked set bit of v, searching upward from the rotate pointer.
  function automatic logic [ID_W:0] pick(input irq_vec_t v, input id_t p);
    logic [ID_W:0] res;
    int idx;
    res = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= NUM_IRQ) idx -= NUM_IRQ;
      if (v[idx[ID_W-1:0]]) res = {1'b1, id_t'(idx)};
    end
    return res;
  endfunction

  function automatic id_t rank_of(input id_t id, input id_t p);
    int r;
    r = int'(id) - int'(p);
    if (r < 0) r += NUM_IRQ;
    return id_t'(r);
  endfunction

  function automatic id_t next_ptr(input id_t id);
    return (int'(id) == NUM_IRQ - 1) ? '0 : id + 1'b1;
  endfunction

  assign unused_wr_data = ^bus.wr_data;

  always_comb begin
    ptr_eff            = ctrl[2] ? ptr : '0;
    pend               = irr & ~mask;
    {p_found, p_id}    = pick(pend, ptr_eff);
    {s_found, s_id}    = pick(isr, ptr_eff);
    eligible = p_found && (!s_found || (rank_of(p_id, ptr_eff) < rank_of(s_id, ptr_eff)));
    ack_go   = bus.inta_req && !vec_valid;
    ack_hit  = ack_go && eligible;
    eoi_wr   = bus.wr_en && (bus.wr_addr == 2'd3);
    if (bus.wr_data[7]) begin
      eoi_eff = int'(bus.wr_data[4:0]) < NUM_IRQ;
      eoi_id  = id_t'(bus.wr_data[4:0]);
    end else begin
      eoi_eff = s_found;
      eoi_id  = s_id;
    end
  end

  always_comb begin
    if (ctrl[0]) begin
      irr_nxt = bus.ir;
    end else begin
      irr_nxt = irr;
      if (ack_hit) irr_nxt[p_id] = 1'b0;
      // A fresh edge in the same cycle as the ack-clear must survive.
      irr_nxt = irr_nxt | (bus.ir & ~ir_q);
    end

    isr_nxt = isr;
    if (eoi_wr && eoi_eff) isr_nxt[eoi_id] = 1'b0;
    if (ack_hit && !ctrl[1]) isr_nxt[p_id] = 1'b1;

    ptr_nxt = ptr;
    if (!ctrl[2]) begin
      ptr_nxt = '0;
    end else begin
      if (ack_hit && ctrl[1]) ptr_nxt = next_ptr(p_id);
      if (eoi_wr && eoi_eff)  ptr_nxt = next_ptr(eoi_id);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irr       <= '0;
      isr       <= '0;
      mask      <= '1;
      ir_q      <= '0;
      ctrl      <= '0;
      base      <= '0;
      ptr       <= '0;
      intr      <= 1'b0;
      vec_valid <= 1'b0;
      vector    <= '0;
      spurious  <= 1'b0;
    end else begin
      ir_q      <= bus.ir;
      irr       <= irr_nxt;
      isr       <= isr_nxt;
      ptr       <= ptr_nxt;
      intr      <= eligible && !ack_go;
      vec_valid <= ack_go;
      if (ack_go) begin
        spurious <= !eligible;
        vector   <= eligible ? base + VEC_W'(p_id) : base + VEC_W'(NUM_IRQ - 1);
      end
      if (bus.wr_en) begin
        case (bus.wr_addr)
          2'd0:    mask <= bus.wr_data[NUM_IRQ-1:0];
          2'd1:    ctrl <= bus.wr_data[2:0];
          2'd2:    base <= bus.wr_data[VEC_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    case (bus.rd_addr)
      2'd0:    bus.rd_data = DATA_W'(irr);
      2'd1:    bus.rd_data = DATA_W'(isr);
      2'd2:    bus.rd_data = DATA_W'(mask);
      default: bus.rd_data = DATA_W'({base, ctrl});
    endcase
  end

  assign bus.intr      = intr;
  assign bus.vec_valid = vec_valid;
  assign bus.vector    = vector;
  assign bus.spurious  = spurious;
endmodule

// File: tb/tb_programmable_irq_ctrl.sv
// Self-checking bench for programmable_irq_ctrl: expected vectors are queued at ack time
// and compared when VEC_VALID appears; register and INT expectations are direct constants.
module tb_programmable_irq_ctrl;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  logic [8:0] sb_q[$];
  logic [8:0] sb_exp;
  logic [31:0] rd_val;

  programmable_irq_ctrl_if #(.NUM_IRQ(8), .DATA_W(32), .VEC_W(8)) bus ();

  programmable_irq_ctrl #(.NUM_IRQ(8), .DATA_W(32), .VEC_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.rd_addr = a;
    #1;
    rd_val = bus.rd_data;
    check_val(tag, rd_val, exp);
  endtask

  task automatic ack(input logic spur, input logic [7:0] vec);
    sb_q.push_back({spur, vec});
    bus.inta_req = 1'b1;
    tick();
    bus.inta_req = 1'b0;
  endtask

  task automatic pulse_ir(input logic [7:0] v);
    bus.ir = v;
    tick();
    bus.ir = '0;
    tick();
  endtask

  // Scoreboard consumer: every VEC_VALID pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.vec_valid) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexp_vld", 32'(bus.vec_valid), 0);
      end else begin
        sb_exp = sb_q.pop_front();
        check_val("vector",   32'(bus.vector),   32'(sb_exp[7:0]));
        check_val("spurious", 32'(bus.spurious), 32'(sb_exp[8]));
        check_val("ack_int",  32'(bus.intr),     0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    n_chk        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.ir       = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_addr  = '0;
    bus.inta_req = 1'b0;
    tick();
    tick();
    check_val("rst_int",  32'(bus.intr),      0);
    check_val("rst_vld",  32'(bus.vec_valid), 0);
    check_val("rst_vec",  32'(bus.vector),    0);
    check_val("rst_spur", 32'(bus.spurious),  0);
    chk_reg("rst_irr",  2'd0, 0);
    chk_reg("rst_isr",  2'd1, 0);
    chk_reg("rst_mask", 2'd2, 'hFF);
    chk_reg("rst_bc",   2'd3, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Edge mode, fixed priority
    wr(2'd0, 0);
    wr(2'd2, 'h20);
    bus.ir = 8'h08;
    tick();
    bus.ir = '0;
    chk_reg("e_irr_set", 2'd0, 'h08);
    check_val("e_int_pre", 32'(bus.intr), 0);
    tick();
    check_val("e_int", 32'(bus.intr), 1);
    ack(1'b0, 8'h23);
    check_val("e_int_ack", 32'(bus.intr), 0);
    chk_reg("e_isr", 2'd1, 'h08);
    chk_reg("e_irr", 2'd0, 0);
    tick();
    check_val("e_int_isr", 32'(bus.intr), 0);
    wr(2'd3, 'h00);
    chk_reg("e_isr_eoi", 2'd1, 0);

    // Nesting
    pulse_ir(8'h20);
    ack(1'b0, 8'h25);
    pulse_ir(8'h04);
    check_val("n_int_nest", 32'(bus.intr), 1);
    ack(1'b0, 8'h22);
    chk_reg("n_isr2", 2'd1, 'h24);
    wr(2'd3, 'h8A);
    chk_reg("n_eoi_oor", 2'd1, 'h24);
    pulse_ir(8'h40);
    tick();
    check_val("n_int_blk", 32'(bus.intr), 0);
    chk_reg("n_irr6", 2'd0, 'h40);
    wr(2'd3, 'h82);
    chk_reg("n_isr_spec", 2'd1, 'h20);
    tick();
    check_val("n_int_blk2", 32'(bus.intr), 0);
    wr(2'd3, 'h00);
    chk_reg("n_isr_ns", 2'd1, 0);
    tick();
    check_val("n_int_rel", 32'(bus.intr), 1);
    ack(1'b0, 8'h26);
    wr(2'd3, 'h86);
    chk_reg("n_isr_clr", 2'd1, 0);

    // Rotation
    wr(2'd1, 'h4);
    wr(2'd3, 'h82);
    pulse_ir(8'h12);
    ack(1'b0, 8'h24);
    chk_reg("r_isr", 2'd1, 'h10);
    chk_reg("r_irr", 2'd0, 'h02);
    wr(2'd3, 'h84);
    tick();
    check_val("r_int1", 32'(bus.intr), 1);
    ack(1'b0, 8'h21);
    chk_reg("r_isr1", 2'd1, 'h02);
    wr(2'd3, 'h00);
    chk_reg("r_isr_clr", 2'd1, 0);
    wr(2'd1, 'h0);

    // Level + auto EOI, with a BASE write in the ack cycle
    wr(2'd1, 'h3);
    chk_reg("l_bc", 2'd3, 'h103);
    bus.ir = 8'h01;
    tick();
    tick();
    check_val("l_int", 32'(bus.intr), 1);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'd2;
    bus.wr_data = 'h40;
    ack(1'b0, 8'h20);
    bus.wr_en   = 1'b0;
    chk_reg("l_isr", 2'd1, 0);
    chk_reg("l_irr", 2'd0, 'h01);
    tick();
    check_val("l_int_re", 32'(bus.intr), 1);
    bus.ir = '0;
    tick();
    tick();
    check_val("l_int_off", 32'(bus.intr), 0);
    wr(2'd1, 'h0);

    // Spurious acknowledge
    wr(2'd0, 'h02);
    pulse_ir(8'h02);
    check_val("s_int", 32'(bus.intr), 0);
    chk_reg("s_irr", 2'd0, 'h02);
    ack(1'b1, 8'h47);
    chk_reg("s_isr", 2'd1, 0);
    chk_reg("s_irr_keep", 2'd0, 'h02);
    chk_reg("s_bc", 2'd3, 'h200);

    // Reset in the cycle after the acknowledge
    wr(2'd0, 0);
    tick();
    check_val("x_int", 32'(bus.intr), 1);
    bus.inta_req = 1'b1;
    tick();
    bus.inta_req = 1'b0;
    check_val("x_vld_pre", 32'(bus.vec_valid), 1);
    rst_n = 1'b0;
    #1;
    check_val("x_vld", 32'(bus.vec_valid), 0);
    check_val("x_int_rst", 32'(bus.intr), 0);
    chk_reg("x_mask", 2'd2, 'hFF);
    chk_reg("x_irr", 2'd0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_val("sb_drain", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
